// File: rtl/qspi_line_arb.sv
// Line-request arbiter between icache/dcache and the QSPI controller; serialises write
// lines and assembles read lines nibble by nibble. Define QSPI_RR_EN for round-robin arbitration.
module qspi_line_arb #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 24,
  parameter int GUARD       = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ic_req,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] ic_addr,
  output logic                              ic_ack,
  input  logic                              dc_req,
  input  logic                              dc_write,
  input  logic                              dc_mem,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] dc_addr,
  input  logic [8*LINE_LENGTH-1:0]          dc_wdata,
  output logic                              dc_ack,
  output logic [8*LINE_LENGTH-1:0]          rdata,
  output logic                              req,
  output logic                              i_d,
  output logic                              mem,
  output logic                              write,
  output logic [PA-$clog2(LINE_LENGTH)-1:0] paddr,
  output logic [3:0]                        dwrite,
  input  logic                              rstrobe_d,
  input  logic                              wstrobe_i,
  input  logic                              wstrobe_d,
  input  logic [3:0]                        uio_in
);

  localparam int AW = PA - $clog2(LINE_LENGTH);
  localparam int NW = $clog2(2*LINE_LENGTH);
  localparam int PW = NW + 1;
  localparam int GW = $clog2(GUARD + 2);
  localparam logic [PW-1:0] LAST  = PW'(2*LINE_LENGTH);
  localparam logic [GW-1:0] GLOAD = GW'(GUARD);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     i_d_q, i_d_d;
  logic                     mem_q, mem_d;
  logic                     write_q, write_d;
  logic [AW-1:0]            paddr_q, paddr_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            guard_q, guard_d;
  logic [8*LINE_LENGTH-1:0] rdata_q, rdata_d;
`ifdef QSPI_RR_EN
  logic                     last_q, last_d;
`endif
  logic                     pick_dc;
  logic                     strobe;
  logic [NW-1:0]            nib;

  // Nibble slot for pointer p: byte p>>1, high nibble when p is even.
  assign nib    = {ptr_q[PW-2:1], ~ptr_q[0]};
  assign strobe = write_q ? rstrobe_d : (wstrobe_i | wstrobe_d);

  assign req    = (state_q == REQ);
  assign ic_ack = (state_q == DONE) &  i_d_q;
  assign dc_ack = (state_q == DONE) & ~i_d_q;
  assign i_d    = i_d_q;
  assign mem    = mem_q;
  assign write  = write_q;
  assign paddr  = paddr_q;
  assign rdata  = rdata_q;
  assign dwrite = (write_q && ptr_q != LAST) ? dc_wdata[{nib, 2'b00} +: 4] : 4'h0;

  always_comb begin
    state_d = state_q;
    i_d_d   = i_d_q;
    mem_d   = mem_q;
    write_d = write_q;
    paddr_d = paddr_q;
    ptr_d   = ptr_q;
    guard_d = guard_q;
    rdata_d = rdata_q;
`ifdef QSPI_RR_EN
    last_d  = last_q;
    pick_dc = dc_req & (~ic_req | ~last_q);
`else
    pick_dc = dc_req;
`endif
    case (state_q)
      IDLE: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (ic_req | dc_req) begin
          i_d_d   = ~pick_dc;
          mem_d   = pick_dc & dc_mem;
          write_d = pick_dc & dc_write;
          paddr_d = pick_dc ? dc_addr : ic_addr;
          ptr_d   = '0;
          state_d = REQ;
`ifdef QSPI_RR_EN
          last_d  = pick_dc;
`endif
        end
      end
      REQ, XFER: begin
        if (strobe) begin
          state_d = XFER;
          if (ptr_q == LAST) begin
            // Surplus strobe: the guard window starts counting from here.
            state_d = DONE;
            guard_d = GLOAD;
          end else begin
            ptr_d = ptr_q + PW'(1);
            if (!write_q) rdata_d[{nib, 2'b00} +: 4] = uio_in;
          end
        end
      end
      DONE: begin
        if (guard_q != '0) guard_d = guard_q - GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_d_q   <= 1'b0;
      mem_q   <= 1'b0;
      write_q <= 1'b0;
      paddr_q <= '0;
      ptr_q   <= '0;
      guard_q <= '0;
      rdata_q <= '0;
`ifdef QSPI_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_d_q   <= i_d_d;
      mem_q   <= mem_d;
      write_q <= write_d;
      paddr_q <= paddr_d;
      ptr_q   <= ptr_d;
      guard_q <= guard_d;
      rdata_q <= rdata_d;
`ifdef QSPI_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
